// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write initiator state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    S_RESET = ST_RESET,
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_RESP  = ST_RESP
  } init_state_e;

endpackage

// File: rtl/axi_lite_write_initiator.sv
// AXI4-Lite write master: takes one local write command, drives AW and W
// independently, waits for B and reports the response on a one-cycle pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// RESET | one cycle after reset release; cmd_ready comes up next
// IDLE  | cmd_ready high, waiting for a command
// ISSUE | AW and/or W still outstanding; each drops on its own handshake
// RESP  | both sent, m_bready high, waiting for the B handshake
module axi_lite_write_initiator
  import axi_lite_pkg::*;
#(
  parameter int ADDRESS_SIZE    = 32,
  parameter int DATA_SIZE       = 32,
  parameter int WRITE_STROBE    = DATA_SIZE / 8,
  parameter int ERR_COUNT_WIDTH = 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [ADDRESS_SIZE-1:0]    cmd_address,
  input  logic [DATA_SIZE-1:0]       cmd_data,
  input  logic [WRITE_STROBE-1:0]    cmd_strobe,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic                       done_valid,
  output logic [1:0]                 done_response,
  output logic [ERR_COUNT_WIDTH-1:0] error_count,
  output logic [ADDRESS_SIZE-1:0]    m_awaddr,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [DATA_SIZE-1:0]       m_wdata,
  output logic [WRITE_STROBE-1:0]    m_wstrb,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  input  logic [1:0]                 m_bresp,
  input  logic                       m_bvalid,
  output logic                       m_bready
);

  init_state_e                state_q, state_d;
  logic                       aw_done_q, aw_done_d;
  logic                       w_done_q, w_done_d;
  logic                       cmd_ready_d, done_valid_d;
  logic [1:0]                 done_response_d;
  logic [ERR_COUNT_WIDTH-1:0] error_count_d;
  logic [ADDRESS_SIZE-1:0]    awaddr_d;
  logic [DATA_SIZE-1:0]       wdata_d;
  logic [WRITE_STROBE-1:0]    wstrb_d;
  logic                       awvalid_d, wvalid_d, bready_d;
  logic                       aw_hs, w_hs, b_hs;

  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;
  assign b_hs  = m_bvalid && m_bready;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d         = state_q;
    aw_done_d       = aw_done_q;
    w_done_d        = w_done_q;
    cmd_ready_d     = cmd_ready;
    done_valid_d    = 1'b0;
    done_response_d = done_response;
    error_count_d   = error_count;
    awaddr_d        = m_awaddr;
    wdata_d         = m_wdata;
    wstrb_d         = m_wstrb;
    awvalid_d       = m_awvalid;
    wvalid_d        = m_wvalid;
    bready_d        = m_bready;

    case (state_q)
      S_RESET: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          awaddr_d    = cmd_address;
          wdata_d     = cmd_data;
          wstrb_d     = cmd_strobe;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          cmd_ready_d = 1'b0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Both channels may finish on the same edge, so include this cycle's handshakes.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = S_RESP;
          bready_d = 1'b1;
        end
      end
      S_RESP: begin
        if (b_hs) begin
          bready_d        = 1'b0;
          done_response_d = m_bresp;
          done_valid_d    = 1'b1;
          cmd_ready_d     = 1'b1;
          state_d         = S_IDLE;
          if (m_bresp != RESP_OKAY && error_count != {ERR_COUNT_WIDTH{1'b1}})
            error_count_d = error_count + ERR_COUNT_WIDTH'(1);
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= S_RESET;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cmd_ready     <= 1'b0;
      done_valid    <= 1'b0;
      done_response <= 2'b00;
      error_count   <= '0;
      m_awaddr      <= '0;
      m_wdata       <= '0;
      m_wstrb       <= '0;
      m_awvalid     <= 1'b0;
      m_wvalid      <= 1'b0;
      m_bready      <= 1'b0;
    end else begin
      state_q       <= state_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      cmd_ready     <= cmd_ready_d;
      done_valid    <= done_valid_d;
      done_response <= done_response_d;
      error_count   <= error_count_d;
      m_awaddr      <= awaddr_d;
      m_wdata       <= wdata_d;
      m_wstrb       <= wstrb_d;
      m_awvalid     <= awvalid_d;
      m_wvalid      <= wvalid_d;
      m_bready      <= bready_d;
    end
  end

endmodule

// File: doc/axi_lite_write_initiator.md
Name: axi_lite_write_initiator

Overview:
- AXI4-Lite write master: the initiating end of the AXI-Lite write channels our subordinate blocks already serve.
- Accepts one write command (address, data, strobe) on a local valid/ready port.
- Drives the AW and W channels independently, waits for B, then returns the response code on a one-cycle done pulse.
- Sits between register-programming logic (sequencers, config loaders) and the AXI-Lite interconnect; keeps a saturating count of error responses.

Parameters:
- ADDRESS_SIZE, 32, address width.
- DATA_SIZE, 32, data width; must be a multiple of 8.
- WRITE_STROBE, DATA_SIZE/8, strobe width, one bit per byte.
- ERR_COUNT_WIDTH, 8, width of the error_count output.

Ports:
- aclk  input  1  clock
- aresetn  input  1  reset, synchronous, active-low
- cmd_address  input  ADDRESS_SIZE  write address
- cmd_data  input  DATA_SIZE  write data
- cmd_strobe  input  WRITE_STROBE  byte enables
- cmd_valid  input  1  command valid
- cmd_ready  output  1  command accepted when valid&&ready
- done_valid  output  1  one-cycle pulse, transaction complete
- done_response  output  2  BRESP of the completed transaction; held until the next done
- error_count  output  ERR_COUNT_WIDTH  saturating count of non-OKAY responses
- m_awaddr  output  ADDRESS_SIZE  AW address
- m_awvalid  output  1  AW valid
- m_awready  input  1  AW ready
- m_wdata  output  DATA_SIZE  W data
- m_wstrb  output  WRITE_STROBE  W strobe
- m_wvalid  output  1  W valid
- m_wready  input  1  W ready
- m_bresp  input  2  B response
- m_bvalid  input  1  B valid
- m_bready  output  1  B ready

Behaviour:
- All outputs are registered.
- Reset: sampled on the aclk edge while aresetn=0. Sets state=RESET, cmd_ready=0, m_awvalid=0, m_wvalid=0, m_bready=0, done_valid=0, done_response=0, error_count=0, m_awaddr/m_wdata/m_wstrb=0.
- Reset mid-transaction: abandons the transaction immediately, with no done pulse. Outstanding-bus cleanup is the system's responsibility.
- RESET: one cycle, then state=IDLE and cmd_ready<=1.
- IDLE: on cmd_valid&&cmd_ready:
  - latch address, data and strobe into m_awaddr/m_wdata/m_wstrb;
  - m_awvalid<=1, m_wvalid<=1, cmd_ready<=0; clear aw_done and w_done; state=ISSUE.
- ISSUE: AW and W are handled independently.
  - On m_awvalid&&m_awready: m_awvalid<=0, aw_done<=1.
  - On m_wvalid&&m_wready: m_wvalid<=0, w_done<=1.
  - Either channel may complete first, or both in the same cycle.
  - Once the cycle's combined completion (registered flags OR this cycle's handshakes) covers both channels: state=RESP, m_bready<=1.
  - m_awvalid and m_wvalid are never dropped before their handshake. m_awaddr/m_wdata/m_wstrb are stable while the corresponding valid is high.
- RESP: on m_bvalid&&m_bready:
  - m_bready<=0; done_response<=m_bresp; done_valid<=1 for exactly one cycle; cmd_ready<=1; state=IDLE.
  - If m_bresp!=2'b00, error_count increments, saturating at all-ones.
- m_bvalid while not in RESP is ignored: m_bready is 0 outside RESP.
- Minimum latency, slave always ready:
  - command accepted at edge N;
  - AW/W handshake at edge N+1;
  - B handshake at edge N+2; done_valid and cmd_ready are high after edge N+2.
  - Throughput: one transaction per 3 cycles.
- cmd_ready=1 in IDLE only; commands are never queued.
- done_valid and cmd_ready rise on the same edge, so a new command can be accepted in the same cycle as done_valid.
- Strobe passes through unmodified; all-zero strobe is legal and still issued.

Decomposition:
- Shared package axi_lite_pkg holds:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the initiator state encoding RESET/IDLE/ISSUE/RESP as 2-bit localparams.
- No sub-module: the saturating counter and FSM stay inline. Size is roughly 150–200 lines.

Test Plan:
- Always-ready slave, BRESP=00:
  - two back-to-back commands 0x10/0xDEADBEEF/4'hF and 0x14/0x12345678/4'h3;
  - each done_valid occurs 3 cycles after its accept, with done_response=00 and error_count=0;
  - m_wstrb shows 4'hF then 4'h3.
- m_awready delayed 3 cycles, m_wready immediate:
  - m_wvalid drops after 1 cycle; m_awvalid is held 4 cycles with m_awaddr stable;
  - m_bready rises only after the AW handshake.
- m_wready delayed 2 cycles, m_awready immediate: symmetric behaviour; one done pulse only.
- Slave returns BRESP=2'b10 with ERR_COUNT_WIDTH=2, for 5 consecutive writes:
  - done_response=10 each time;
  - error_count steps 1,2,3,3,3;
  - a following OKAY write leaves it at 3.
- m_bvalid asserted during ISSUE: ignored, with m_bready=0; it completes only after entering RESP.
- aresetn low for 1 cycle while in RESP: no done_valid; all outputs at reset values next cycle; cmd_ready=1 one cycle after aresetn returns high; error_count=0.
